// File: rtl/middle_ram_mean_sequencer_pkg.sv
// Shared constants for the 3x3 block-mean sequencer: tap count, reciprocal
// scaling, row-major tap offset table and FSM state encoding.
package middle_ram_mean_sequencer_pkg;

    localparam int MEAN_TAPS  = 9;
    localparam int MEAN_RECIP = 57;
    localparam int MEAN_SHIFT = 9;

    // Row-major: dr outer, dc inner, both -1..+1
    localparam logic signed [1:0] TAP_DC [0:MEAN_TAPS-1] = '{
        -2'sd1, 2'sd0, 2'sd1,
        -2'sd1, 2'sd0, 2'sd1,
        -2'sd1, 2'sd0, 2'sd1
    };
    localparam logic signed [1:0] TAP_DR [0:MEAN_TAPS-1] = '{
        -2'sd1, -2'sd1, -2'sd1,
         2'sd0,  2'sd0,  2'sd0,
         2'sd1,  2'sd1,  2'sd1
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mean_state_e;

endpackage

// File: rtl/middle_ram_mean_sequencer_if.sv
// Request/result handshake plus the middle RAM read port of the sequencer.
interface middle_ram_mean_sequencer_if #(
    parameter int COORD_W = 8,
    parameter int DATA_W  = 8
);
    logic               iStart;
    logic [COORD_W-1:0] iCol;
    logic [COORD_W-1:0] iRow;
    logic               oBusy;
    logic               oDone;
    logic [DATA_W-1:0]  oMean;
    logic [COORD_W-1:0] oRdcol;
    logic [COORD_W-1:0] oRdrow;
    logic [DATA_W-1:0]  iRddata;

    modport slave (
        input  iStart, iCol, iRow, iRddata,
        output oBusy, oDone, oMean, oRdcol, oRdrow
    );

    modport master (
        output iStart, iCol, iRow, iRddata,
        input  oBusy, oDone, oMean, oRdcol, oRdrow
    );
endinterface

// File: rtl/middle_ram_mean_sequencer_coord_clamp.sv
// Adds a -1/0/+1 tap offset to a grid coordinate and saturates to [0, MAX];
// two guard bits keep the signed sum from wrapping at either end.
module middle_ram_mean_sequencer_coord_clamp #(
    parameter int COORD_W = 8,
    parameter int MAX     = 127
) (
    input  logic [COORD_W-1:0] base_i,
    input  logic signed [1:0]  off_i,
    output logic [COORD_W-1:0] coord_o
);
    localparam int SW = COORD_W + 2;
    localparam logic signed [SW-1:0] MAX_S = SW'(MAX);

    logic signed [SW-1:0] base_s;
    logic signed [SW-1:0] off_s;
    logic signed [SW-1:0] sum_s;

    assign base_s = $signed({2'b00, base_i});
    assign off_s  = SW'(off_i);
    assign sum_s  = base_s + off_s;

    always_comb begin
        if (sum_s < 0)
            coord_o = '0;
        else if (sum_s > MAX_S)
            coord_o = COORD_W'(MAX);
        else
            coord_o = sum_s[COORD_W-1:0];
    end
endmodule

// File: rtl/middle_ram_mean_sequencer.sv
// Walks the 3x3 clamped neighbourhood of a block in the middle RAM, sums the
// nine taps in pipeline with the address issue, and returns the scaled mean.
module middle_ram_mean_sequencer
    import middle_ram_mean_sequencer_pkg::*;
#(
    parameter int COORD_W = 8,
    parameter int DATA_W  = 8,
    parameter int COL_MAX = 127,
    parameter int ROW_MAX = 127
) (
    input  logic                          clock,
    input  logic                          reset,
    middle_ram_mean_sequencer_if.slave    bus
);
    localparam int SUM_W  = DATA_W + 4;
    localparam int PROD_W = SUM_W + 6;

    mean_state_e        state_q, state_d;
    logic [3:0]         tap_q, tap_d;
    logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
    logic [COORD_W-1:0] rdcol_q, rdcol_d, rdrow_q, rdrow_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [DATA_W-1:0]  mean_q, mean_d;

    logic [COORD_W-1:0] in_col, in_row, base_col, base_row, tap_col, tap_row;
    logic [3:0]         tap_idx;

    // Truncating reciprocal multiply: sum/9 ~= (sum*57)>>9, exact on uniform input
    function automatic logic [DATA_W-1:0] calc_mean(input logic [SUM_W-1:0] s);
        return DATA_W'((PROD_W'(s) * PROD_W'(MEAN_RECIP)) >> MEAN_SHIFT);
    endfunction

    assign in_col = (bus.iCol > COORD_W'(COL_MAX)) ? COORD_W'(COL_MAX) : bus.iCol;
    assign in_row = (bus.iRow > COORD_W'(ROW_MAX)) ? COORD_W'(ROW_MAX) : bus.iRow;

    middle_ram_mean_sequencer_coord_clamp #(.COORD_W(COORD_W), .MAX(COL_MAX)) u_clamp_col (
        .base_i (base_col),
        .off_i  (TAP_DC[tap_idx]),
        .coord_o(tap_col)
    );

    middle_ram_mean_sequencer_coord_clamp #(.COORD_W(COORD_W), .MAX(ROW_MAX)) u_clamp_row (
        .base_i (base_row),
        .off_i  (TAP_DR[tap_idx]),
        .coord_o(tap_row)
    );

    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        col_d    = col_q;
        row_d    = row_q;
        rdcol_d  = rdcol_q;
        rdrow_d  = rdrow_q;
        sum_d    = sum_q;
        mean_d   = mean_q;
        base_col = col_q;
        base_row = row_q;
        tap_idx  = (tap_q < 4'(MEAN_TAPS)) ? tap_q : 4'd0;

        case (state_q)
            ST_IDLE: begin
                base_col = in_col;
                base_row = in_row;
                tap_idx  = 4'd0;
                if (bus.iStart) begin
                    state_d = ST_ISSUE;
                    col_d   = in_col;
                    row_d   = in_row;
                    rdcol_d = tap_col;
                    rdrow_d = tap_row;
                    tap_d   = 4'd1;
                    sum_d   = '0;
                end
            end
            ST_ISSUE: begin
                // Read data lags its address by one cycle, so tap 0 lands when tap_q==2
                if (tap_q >= 4'd2)
                    sum_d = sum_q + SUM_W'(bus.iRddata);
                if (tap_q == 4'(MEAN_TAPS)) begin
                    state_d = ST_DRAIN;
                end else begin
                    rdcol_d = tap_col;
                    rdrow_d = tap_row;
                    tap_d   = tap_q + 4'd1;
                end
            end
            ST_DRAIN: begin
                sum_d   = sum_q + SUM_W'(bus.iRddata);
                mean_d  = calc_mean(sum_d);
                tap_d   = 4'd0;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tap_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            rdcol_q <= '0;
            rdrow_q <= '0;
            sum_q   <= '0;
            mean_q  <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            col_q   <= col_d;
            row_q   <= row_d;
            rdcol_q <= rdcol_d;
            rdrow_q <= rdrow_d;
            sum_q   <= sum_d;
            mean_q  <= mean_d;
        end
    end

    assign bus.oBusy  = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign bus.oDone  = (state_q == ST_DONE);
    assign bus.oMean  = mean_q;
    assign bus.oRdcol = rdcol_q;
    assign bus.oRdrow = rdrow_q;
endmodule

// File: tb/tb_middle_ram_mean_sequencer.sv
// Scoreboard bench for the 3x3 block-mean sequencer with a registered-read RAM model.
module tb_middle_ram_mean_sequencer;
    localparam int COORD_W = 8;
    localparam int DATA_W  = 8;
    localparam int GMAX    = 127;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    middle_ram_mean_sequencer_if #(.COORD_W(COORD_W), .DATA_W(DATA_W)) ifc ();

    middle_ram_mean_sequencer #(
        .COORD_W(COORD_W), .DATA_W(DATA_W), .COL_MAX(GMAX), .ROW_MAX(GMAX)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (ifc.slave)
    );

    logic [7:0] mem [256][256];
    logic [7:0] rdd;
    always @(posedge clock) rdd <= mem[ifc.oRdrow][ifc.oRdcol];
    assign ifc.iRddata = rdd;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clip(input int v, input int mx);
        if (v < 0) return 0;
        if (v > mx) return mx;
        return v;
    endfunction

    // Reference: average of the nine clamped neighbours, scaled by 57/512
    function automatic int model_mean(input int c, input int r);
        int cc, rr, sum;
        cc  = clip(c, GMAX);
        rr  = clip(r, GMAX);
        sum = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                sum += int'(mem[clip(rr + dr, GMAX)][clip(cc + dc, GMAX)]);
        return (sum * 57) >> 9;
    endfunction

    task automatic fill_const(input int v);
        for (int r = 0; r < 256; r++)
            for (int c = 0; c < 256; c++)
                mem[r][c] = 8'(v);
    endtask

    task automatic fill_diag();
        for (int r = 0; r < 256; r++)
            for (int c = 0; c < 256; c++)
                mem[r][c] = 8'((r + c) & 255);
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 256; r++)
            for (int c = 0; c < 256; c++)
                mem[r][c] = 8'($urandom_range(0, 255));
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (!reset && ifc.oDone) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected mean=%0d at %0t", ifc.oMean, $time);
            end else begin
                chk("mean", int'(ifc.oMean), exp_q.pop_front());
            end
        end
    end

    // One request; inj_k>0 drives a stray (3,3) start during cycle t+inj_k
    task automatic run_req(input int c, input int r, input int inj_k);
        int cc, rr, tap;
        @(negedge clock);
        ifc.iStart = 1'b1;
        ifc.iCol   = 8'(c);
        ifc.iRow   = 8'(r);
        @(posedge clock);
        exp_q.push_back(model_mean(c, r));
        cc = clip(c, GMAX);
        rr = clip(r, GMAX);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clock);
            if (k == 1) ifc.iStart = 1'b0;
            if (inj_k != 0 && k == inj_k) begin
                ifc.iStart = 1'b1;
                ifc.iCol   = 8'd3;
                ifc.iRow   = 8'd3;
            end else if (inj_k != 0 && k == inj_k + 1) begin
                ifc.iStart = 1'b0;
            end
            tap = (k <= 9) ? k - 1 : 8;
            chk("busy", int'(ifc.oBusy), int'(k <= 10));
            chk("done_timing", int'(ifc.oDone), int'(k == 11));
            chk("rdcol", int'(ifc.oRdcol), clip(cc + (tap % 3) - 1, GMAX));
            chk("rdrow", int'(ifc.oRdrow), clip(rr + (tap / 3) - 1, GMAX));
        end
    endtask

    // Request aborted by reset during cycle t+5
    task automatic abort_req(input int c, input int r);
        int done_seen;
        @(negedge clock);
        ifc.iStart = 1'b1;
        ifc.iCol   = 8'(c);
        ifc.iRow   = 8'(r);
        @(posedge clock);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            if (k == 1) ifc.iStart = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        chk("abort_busy", int'(ifc.oBusy), 0);
        chk("abort_done", int'(ifc.oDone), 0);
        chk("abort_mean", int'(ifc.oMean), 0);
        reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            if (ifc.oDone) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
    endtask

    initial begin
        reset      = 1'b1;
        ifc.iStart = 1'b0;
        ifc.iCol   = '0;
        ifc.iRow   = '0;
        fill_const(8'h80);
        repeat (3) @(negedge clock);
        chk("rst_busy",  int'(ifc.oBusy),  0);
        chk("rst_done",  int'(ifc.oDone),  0);
        chk("rst_mean",  int'(ifc.oMean),  0);
        chk("rst_rdcol", int'(ifc.oRdcol), 0);
        chk("rst_rdrow", int'(ifc.oRdrow), 0);
        reset = 1'b0;

        run_req(5, 5, 0);
        chk("uniform_model", model_mean(5, 5), 128);

        fill_diag();
        run_req(10, 10, 0);
        chk("diag_model", model_mean(10, 10), 20);
        run_req(0, 0, 0);
        run_req(127, 127, 0);
        chk("corner_model", model_mean(127, 127), 253);
        run_req(200, 255, 0);

        fill_const(8'hFF);
        run_req(127, 127, 0);
        chk("sat_model", model_mean(127, 127), 255);

        fill_diag();
        run_req(10, 10, 4);
        run_req(3, 3, 0);

        abort_req(10, 10);
        run_req(10, 10, 0);

        fill_rand();
        for (int i = 0; i < 20; i++)
            run_req(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0);

        repeat (4) @(negedge clock);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
